reg_load_scoreboard: RTL and testbench



---
 rtl/reg_load_scoreboard_if.sv | 32 +++
 rtl/reg_load_scoreboard.sv | 96 +++++++++
 tb/tb_reg_load_scoreboard.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_load_scoreboard_if.sv
// Issue / write-back bundle between the pipeline control and the register load scoreboard.
// The master side is the issue and write-back logic. The slave side is the scoreboard.
interface reg_load_scoreboard_if #(
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8
) ();
    logic                rsv_valid;
    logic [ADDR_W-1:0]   rsv_dest;
    logic                rsv_ready;
    logic                wb_valid;
    logic [ADDR_W-1:0]   wb_dest;
    logic [DATA_W-1:0]   wb_data;
    logic [ADDR_W-1:0]   src_a;
    logic [ADDR_W-1:0]   src_b;
    logic                hazard;
    logic [NUM_REGS-1:0] load;
    logic [DATA_W-1:0]   load_data;
    logic [NUM_REGS-1:0] busy;
    logic                wb_err;
    logic                err_clr;

    modport master (
        output rsv_valid, rsv_dest, wb_valid, wb_dest, wb_data, src_a, src_b, err_clr,
        input  rsv_ready, hazard, load, load_data, busy, wb_err
    );

    modport slave (
        input  rsv_valid, rsv_dest, wb_valid, wb_dest, wb_data, src_a, src_b, err_clr,
        output rsv_ready, hazard, load, load_data, busy, wb_err
    );
endinterface

// File: rtl/reg_load_scoreboard.sv
// Write-back destination decoder with a registered one-hot load strobe and registered data.
// A per-register busy scoreboard supports hazard detection and blocks double reservation.
module reg_load_scoreboard #(
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 4,
    parameter int DATA_W   = 8,
    parameter int STRICT   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_load_scoreboard_if.slave  bus
);
    localparam bit LOOSE = (STRICT == 0);

    // One-hot decode. An out-of-range index decodes to all zeros, so range checks reduce to an OR.
    function automatic logic [NUM_REGS-1:0] dec(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            oh[i] = (idx == ADDR_W'(i));
        end
        return oh;
    endfunction

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [NUM_REGS-1:0] load_q, load_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;
    logic                wb_err_q, wb_err_d;

    logic [NUM_REGS-1:0] rsv_oh_s, wb_oh_s;
    logic                rsv_in_s, wb_in_s, rsv_busy_s, wb_busy_s;
    logic                rsv_ready_s, rsv_take_s, wb_ok_s, err_ev_s;

    // Decode requests against the registered scoreboard and form next state.
    always_comb begin
        rsv_oh_s    = dec(bus.rsv_dest);
        wb_oh_s     = dec(bus.wb_dest);
        rsv_in_s    = |rsv_oh_s;
        wb_in_s     = |wb_oh_s;
        rsv_busy_s  = |(rsv_oh_s & busy_q);
        wb_busy_s   = |(wb_oh_s & busy_q);
        // A busy register may be re-reserved while its write-back lands in the same cycle.
        rsv_ready_s = ~rsv_in_s | ~rsv_busy_s |
                      (bus.wb_valid & (bus.wb_dest == bus.rsv_dest));
        rsv_take_s  = bus.rsv_valid & rsv_ready_s & rsv_in_s;
        wb_ok_s     = bus.wb_valid & wb_in_s & (wb_busy_s | LOOSE);
        err_ev_s    = (bus.rsv_valid & ~rsv_in_s) | (bus.wb_valid & ~wb_ok_s);

        busy_d      = busy_q;
        load_d      = '0;
        load_data_d = load_data_q;
        if (wb_ok_s) begin
            busy_d      = busy_d & ~wb_oh_s;
            load_d      = wb_oh_s;
            load_data_d = bus.wb_data;
        end else begin
            load_d      = '0;
        end
        // The set is applied after the clear so a same-cycle reservation wins.
        if (rsv_take_s) begin
            busy_d = busy_d | rsv_oh_s;
        end else begin
            busy_d = busy_d;
        end

        if (err_ev_s) begin
            wb_err_d = 1'b1;
        end else if (bus.err_clr) begin
            wb_err_d = 1'b0;
        end else begin
            wb_err_d = wb_err_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            load_q      <= '0;
            load_data_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            load_q      <= load_d;
            load_data_q <= load_data_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign bus.rsv_ready = rsv_ready_s;
    assign bus.hazard    = |((dec(bus.src_a) | dec(bus.src_b)) & busy_q);
    assign bus.load      = load_q;
    assign bus.load_data = load_data_q;
    assign bus.busy      = busy_q;
    assign bus.wb_err    = wb_err_q;
endmodule

// File: tb/tb_reg_load_scoreboard.sv
// Scoreboard bench for reg_load_scoreboard with three builds driven in lockstep.
// The builds are: strict with 4 registers, non-strict with 4 registers, and strict with 3 registers.
module tb_reg_load_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_load_scoreboard_if #(.ADDR_W(2), .NUM_REGS(4), .DATA_W(8)) i0 ();
    reg_load_scoreboard_if #(.ADDR_W(2), .NUM_REGS(4), .DATA_W(8)) i1 ();
    reg_load_scoreboard_if #(.ADDR_W(2), .NUM_REGS(3), .DATA_W(8)) i2 ();

    reg_load_scoreboard #(.ADDR_W(2), .NUM_REGS(4), .DATA_W(8), .STRICT(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    reg_load_scoreboard #(.ADDR_W(2), .NUM_REGS(4), .DATA_W(8), .STRICT(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    reg_load_scoreboard #(.ADDR_W(2), .NUM_REGS(3), .DATA_W(8), .STRICT(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

    typedef struct {
        int         cyc;
        logic [3:0] ld;
        logic [7:0] dat;
    } ev_t;

    ev_t        q0[$], q1[$], q2[$];
    int         nr[3] = '{4, 4, 3};
    bit         st[3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] mb[3];
    logic       merr[3];
    logic [7:0] mld[3];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    bit         mon_on = 1'b0;

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", nm, k, act, exp);
        end
    endtask

    function automatic logic [1:0] comb_out(int k);
        case (k)
            0:       return {i0.rsv_ready, i0.hazard};
            1:       return {i1.rsv_ready, i1.hazard};
            default: return {i2.rsv_ready, i2.hazard};
        endcase
    endfunction

    // Returns {wb_err, busy, load, load_data}, with busy and load zero-extended to 4 bits.
    function automatic logic [16:0] reg_out(int k);
        case (k)
            0:       return {i0.wb_err, i0.busy, i0.load, i0.load_data};
            1:       return {i1.wb_err, i1.busy, i1.load, i1.load_data};
            default: return {i2.wb_err, 1'b0, i2.busy, 1'b0, i2.load, i2.load_data};
        endcase
    endfunction

    task automatic push_ev(int k, ev_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic take(int k, output ev_t e, output bit have);
        have = 1'b0;
        e = '{0, 4'h0, 8'h00};
        case (k)
            0:       if (q0.size() > 0 && q0[0].cyc == cyc) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0 && q1[0].cyc == cyc) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0 && q2[0].cyc == cyc) begin e = q2.pop_front(); have = 1'b1; end
        endcase
    endtask

    function automatic int qsize(int k);
        case (k)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Drive one cycle of stimulus, check combinational outputs, and advance the reference model.
    task automatic apply(bit rv, int rd, bit wv, int wd, logic [7:0] wdat, int sa, int sb, bit ec, bit rstn);
        @(negedge clk);
        rst_n = rstn;
        i0.rsv_valid = rv;      i1.rsv_valid = rv;      i2.rsv_valid = rv;
        i0.rsv_dest = 2'(rd);   i1.rsv_dest = 2'(rd);   i2.rsv_dest = 2'(rd);
        i0.wb_valid = wv;       i1.wb_valid = wv;       i2.wb_valid = wv;
        i0.wb_dest = 2'(wd);    i1.wb_dest = 2'(wd);    i2.wb_dest = 2'(wd);
        i0.wb_data = wdat;      i1.wb_data = wdat;      i2.wb_data = wdat;
        i0.src_a = 2'(sa);      i1.src_a = 2'(sa);      i2.src_a = 2'(sa);
        i0.src_b = 2'(sb);      i1.src_b = 2'(sb);      i2.src_b = 2'(sb);
        i0.err_clr = ec;        i1.err_clr = ec;        i2.err_clr = ec;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] b;
            bit rin, win, rbusy, wbusy, rdy, haz, wok, err;
            ev_t e;
            b     = mb[k];
            rin   = rd < nr[k];
            win   = wd < nr[k];
            rbusy = rin && b[rd];
            wbusy = win && b[wd];
            rdy   = !rin || !rbusy || (wv && wd == rd);
            haz   = (sa < nr[k] && b[sa]) || (sb < nr[k] && b[sb]);
            if (mon_on) begin
                chk("rsv_ready", k, 32'(comb_out(k) >> 1), 32'(rdy));
                chk("hazard", k, 32'(comb_out(k) & 2'b01), 32'(haz));
            end
            if (!rstn) begin
                mb[k]   = 4'h0;
                merr[k] = 1'b0;
                mld[k]  = 8'h00;
            end else begin
                wok = wv && win && (wbusy || !st[k]);
                err = (rv && !rin) || (wv && !wok);
                if (wok) begin
                    b[wd] = 1'b0;
                    e.cyc = cyc + 1;
                    e.ld  = 4'(1 << wd);
                    e.dat = wdat;
                    push_ev(k, e);
                    mld[k] = wdat;
                end
                if (rv && rdy && rin) b[rd] = 1'b1;
                mb[k] = b;
                if (err) merr[k] = 1'b1;
                else if (ec) merr[k] = 1'b0;
            end
        end
        mon_on = 1'b1;
    endtask

    task automatic idle(int sa = 0, int rd = 0);
        apply(1'b0, rd, 1'b0, 0, 8'h00, sa, 0, 1'b0, 1'b1);
    endtask

    // Monitor: after each edge, pop any load due this cycle and compare all registered outputs.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (mon_on) begin
                for (int k = 0; k < 3; k++) begin
                    ev_t e;
                    bit have;
                    logic [16:0] r;
                    r = reg_out(k);
                    take(k, e, have);
                    if (have) begin
                        chk("load", k, 32'(r[11:8]), 32'(e.ld));
                        chk("load_data", k, 32'(r[7:0]), 32'(e.dat));
                    end else begin
                        chk("load_idle", k, 32'(r[11:8]), 32'h0);
                        chk("load_data_hold", k, 32'(r[7:0]), 32'(mld[k]));
                    end
                    chk("load_onehot", k, 32'($onehot0(r[11:8])), 32'h1);
                    chk("busy", k, 32'(r[15:12]), 32'(mb[k]));
                    chk("wb_err", k, 32'(r[16]), 32'(merr[k]));
                end
            end
        end
    end

    initial begin
        // Reset for two cycles, then idle across every reservation destination.
        apply(1'b0, 0, 1'b1, 1, 8'h11, 0, 0, 1'b0, 1'b0);
        apply(1'b0, 0, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b0);
        for (int d = 0; d < 4; d++) idle(d, d);
        // Reserve register 2, retry it (blocked), then write it back.
        apply(1'b1, 2, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b1);
        apply(1'b1, 2, 1'b0, 0, 8'h00, 2, 0, 1'b0, 1'b1);
        apply(1'b0, 0, 1'b1, 2, 8'hA5, 2, 0, 1'b0, 1'b1);
        idle(2);
        // Same-cycle handoff on register 1.
        apply(1'b1, 1, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b1);
        apply(1'b1, 1, 1'b1, 1, 8'h3C, 1, 0, 1'b0, 1'b1);
        idle(1);
        apply(1'b0, 0, 1'b1, 1, 8'h77, 0, 1, 1'b0, 1'b1);
        // Write-back to a non-busy register, then err_clr with and without a new error.
        apply(1'b0, 0, 1'b1, 3, 8'h5A, 0, 0, 1'b0, 1'b1);
        apply(1'b0, 0, 1'b1, 3, 8'h5B, 0, 0, 1'b1, 1'b1);
        apply(1'b0, 0, 1'b0, 0, 8'h00, 0, 0, 1'b1, 1'b1);
        idle();
        // Reserve every destination, then write each back with data dest+8'h10.
        for (int d = 0; d < 4; d++) apply(1'b1, d, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b1);
        for (int d = 0; d < 4; d++) apply(1'b0, 0, 1'b1, d, 8'(d + 16), d, 3 - d, 1'b0, 1'b1);
        apply(1'b0, 0, 1'b0, 0, 8'h00, 0, 0, 1'b1, 1'b1);
        // Reset in the middle of a write-back with busy=0110.
        apply(1'b1, 1, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b1);
        apply(1'b1, 2, 1'b0, 0, 8'h00, 0, 0, 1'b0, 1'b1);
        apply(1'b0, 0, 1'b1, 1, 8'hEE, 1, 2, 1'b0, 1'b0);
        idle(1);
        // Randomized traffic.
        repeat (400) begin
            apply(1'($urandom_range(0, 2) != 0), $urandom_range(0, 3),
                  1'($urandom_range(0, 2) != 0), $urandom_range(0, 3), 8'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) != 0));
        end
        idle();
        @(posedge clk);
        #2;
        for (int k = 0; k < 3; k++) chk("pending_loads", k, 32'(qsize(k)), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
